// File: rtl/fc_seq_ctrl.sv
// Fully-connected layer sequencer: buffers one input vector, then walks the
// neuron result mux one index at a time and hands each settled result downstream.
module fc_seq_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned IN     = 128,
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned Z_W    = 23,
  parameter int unsigned SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic [WIDTH*IN-1:0]        x_vec,
  output logic [$clog2(N_OUT)-1:0]   nsel,
  input  logic [Z_W-1:0]             z_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [Z_W-1:0]             out_data,
  output logic [$clog2(N_OUT)-1:0]   out_idx,
  output logic                       out_last,
  output logic                       busy
);

  localparam int unsigned NSEL_W = $clog2(N_OUT);
  localparam int unsigned PTR_W  = $clog2(IN);
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(IN - 1);
  localparam logic [NSEL_W-1:0] NSEL_LAST = NSEL_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_WAIT = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [NSEL_W-1:0]   r_nsel;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_out_valid;
  logic                r_out_last;
  logic [Z_W-1:0]      r_out_data;
  logic [NSEL_W-1:0]   r_out_idx;
  logic [WIDTH-1:0]    r_buf [IN];

  logic w_accept;
  logic w_handshake;

  // r_in_ready is only ever high in LOAD, so it also gates buffer writes.
  assign w_accept    = in_valid && r_in_ready;
  assign w_handshake = r_out_valid && out_ready;

  assign in_ready  = r_in_ready;
  assign nsel      = r_nsel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

  // Sequencer FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_wr_ptr    <= '0;
      r_nsel      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            if (r_wr_ptr == PTR_LAST) begin
              r_wr_ptr   <= '0;
              r_nsel     <= '0;
              r_cnt      <= CNT_LOAD;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= S_WAIT;
            end else begin
              r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
          end
        end
        S_WAIT: begin
          // Counter reaching zero means z_in has had SETTLE cycles since nsel moved.
          if (r_cnt == '0) begin
            r_out_data  <= z_in;
            r_out_idx   <= r_nsel;
            r_out_last  <= (r_nsel == NSEL_LAST);
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_EMIT: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_nsel == NSEL_LAST) begin
              r_nsel     <= '0;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_LOAD;
            end else begin
              r_nsel  <= r_nsel + NSEL_W'(1);
              r_cnt   <= CNT_LOAD;
              r_state <= S_WAIT;
            end
          end
        end
        default: begin
          r_state    <= S_LOAD;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Input vector buffer; frozen whenever the sequencer is not in LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(IN); i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_accept) begin
      r_buf[r_wr_ptr] <= in_data;
    end
  end

  for (genvar g = 0; g < int'(IN); g++) begin : g_xvec
    assign x_vec[g*WIDTH +: WIDTH] = r_buf[g];
  end

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Directed bench for fc_seq_ctrl: SETTLE=2 main instance plus a SETTLE=1 instance
// checked on the first frame.
module tb_fc_seq_ctrl;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned IN     = 128;
  localparam int unsigned N_OUT  = 10;
  localparam int unsigned Z_W    = 23;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned NSEL_W = $clog2(N_OUT);

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_valid = 1'b0;
  logic [WIDTH-1:0]      in_data = '0;
  logic                  out_ready = 1'b0;

  logic                  in_ready, out_valid, out_last, busy;
  logic [WIDTH*IN-1:0]   x_vec;
  logic [NSEL_W-1:0]     nsel, out_idx;
  logic [Z_W-1:0]        z_in, out_data;

  logic                  in_ready1, out_valid1, out_last1, busy1;
  logic [WIDTH*IN-1:0]   x_vec1;
  logic [NSEL_W-1:0]     nsel1, out_idx1;
  logic [Z_W-1:0]        z_in1, out_data1;

  int n_chk = 0;
  int n_err = 0;
  int edge_cnt = 0;
  logic [WIDTH*IN-1:0] exp_vec = '0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  fc_seq_ctrl #(.WIDTH(WIDTH), .IN(IN), .N_OUT(N_OUT), .Z_W(Z_W), .SETTLE(SETTLE)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .x_vec(x_vec), .nsel(nsel), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  fc_seq_ctrl #(.WIDTH(WIDTH), .IN(IN), .N_OUT(N_OUT), .Z_W(Z_W), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .x_vec(x_vec1), .nsel(nsel1), .z_in(z_in1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1), .busy(busy1)
  );

  // Neuron model: result only becomes valid SETTLE cycles after nsel moves.
  int age = 100;
  logic [NSEL_W-1:0] last_nsel = '0;
  always begin
    @(posedge clk);
    #1;
    if (nsel !== last_nsel) begin
      last_nsel = nsel;
      age = 0;
    end else if (age < 100) begin
      age = age + 1;
    end
  end
  assign z_in  = (age >= int'(SETTLE) - 1) ? Z_W'(32'(nsel) * 100 + 5) : {Z_W{1'b1}};
  assign z_in1 = Z_W'(32'(nsel1) * 100 + 5);

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Second-instance monitor, sampled after the main thread has set out_ready.
  bit mon1_en = 1'b0;
  int mon1_idx = 0;
  int mon1_start = 0;
  always begin
    @(posedge clk);
    #2;
    if (mon1_en && out_valid1 && out_ready) begin
      chk("s1_data", 64'(out_data1), 64'(mon1_idx * 100 + 5));
      chk("s1_idx", 64'(out_idx1), 64'(mon1_idx));
      if (out_last1) begin
        chk("s1_frame", 64'(edge_cnt + 1 - mon1_start), 64'(148));
        mon1_en = 1'b0;
      end
      mon1_idx++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_idx", 64'(out_idx), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_nsel", 64'(nsel), 64'(0));
    chk("rst_xvec_zero", 64'(x_vec == '0), 64'(1));
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    tick();
    chk("rst_in_ready_c1", 64'(in_ready), 64'(1));
    chk("rst_out_valid_c1", 64'(out_valid), 64'(0));
  endtask

  // mode 0: data=i, 1: random, 2: i^0x5A. bubble toggles in_valid every cycle.
  task automatic load_vec(input bit bubble, input int mode, input int n);
    int i;
    int guard;
    bit phase;
    logic [WIDTH-1:0] d;
    i = 0;
    guard = 0;
    phase = 1'b0;
    chk("load_ready", 64'(in_ready), 64'(1));
    while (i < n && guard < 4 * int'(IN)) begin
      guard++;
      if (bubble && !phase) begin
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
      end else begin
        d = (mode == 0) ? WIDTH'(i) : (mode == 1) ? WIDTH'($urandom) : WIDTH'(i ^ 32'h5A);
        in_valid = 1'b1;
        in_data  = d;
        exp_vec[i*WIDTH +: WIDTH] = d;
        i++;
      end
      phase = !phase;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic post_load();
    chk("load_xvec", 64'(x_vec == exp_vec), 64'(1));
    chk("load_busy", 64'(busy), 64'(1));
    chk("load_ready_low", 64'(in_ready), 64'(0));
  endtask

  task automatic drain(input int bp_idx, input bit hold_ff, input int stop_idx, output int ticks);
    int bp_left;
    int gap;
    int exp_idx;
    bit done;
    bp_left = 7;
    gap = -1;
    exp_idx = 0;
    done = 1'b0;
    ticks = 0;
    while (ticks < 400) begin
      chk("xvec_frozen", 64'(x_vec == exp_vec), 64'(1));
      chk("nsel", 64'(nsel), 64'(exp_idx));
      if (hold_ff) begin
        in_valid = 1'b1;
        in_data  = 8'hFF;
        chk("in_ready_blocked", 64'(in_ready), 64'(0));
      end
      if (gap >= 0) begin
        gap++;
        if (out_valid) begin
          chk("bp_gap", 64'(gap), 64'(3));
          gap = -1;
        end
      end
      out_ready = 1'b1;
      if (out_valid) begin
        if (stop_idx >= 0 && int'(out_idx) == stop_idx) begin
          done = 1'b1;
          break;
        end else if (int'(out_idx) == bp_idx && bp_left > 0) begin
          out_ready = 1'b0;
          chk("bp_hold_data", 64'(out_data), 64'(bp_idx * 100 + 5));
          chk("bp_hold_idx", 64'(out_idx), 64'(bp_idx));
          bp_left--;
        end else begin
          chk("res_data", 64'(out_data), 64'(exp_idx * 100 + 5));
          chk("res_idx", 64'(out_idx), 64'(exp_idx));
          chk("res_last", 64'(out_last), 64'(exp_idx == int'(N_OUT) - 1));
          if (int'(out_idx) == bp_idx) gap = 0;
          done = (exp_idx == int'(N_OUT) - 1);
          exp_idx++;
        end
      end
      tick();
      ticks++;
      if (done) break;
    end
    in_valid = 1'b0;
    chk("drain_done", 64'(done), 64'(1));
    if (done && stop_idx < 0) begin
      chk("end_in_ready", 64'(in_ready), 64'(1));
      chk("end_busy", 64'(busy), 64'(0));
      chk("end_out_valid", 64'(out_valid), 64'(0));
      chk("end_out_last", 64'(out_last), 64'(0));
    end
  endtask

  int t;
  int start;

  initial begin
    #3;
    do_reset();

    // Back-to-back frame, both instances.
    out_ready  = 1'b1;
    mon1_idx   = 0;
    mon1_start = edge_cnt;
    mon1_en    = 1'b1;
    load_vec(1'b0, 0, int'(IN));
    post_load();
    chk("s1_xvec", 64'(x_vec1 == exp_vec), 64'(1));
    drain(-1, 1'b0, -1, t);
    chk("frame_cycles", 64'(int'(IN) + t), 64'(158));
    chk("s1_mon_done", 64'(mon1_en), 64'(0));
    chk("s1_idle_ready", 64'(in_ready1), 64'(1));
    chk("s1_idle_busy", 64'(busy1), 64'(0));

    // Backpressure on idx 3.
    load_vec(1'b0, 2, int'(IN));
    post_load();
    drain(3, 1'b0, -1, t);

    // Bubbled input with in_valid/0xFF held high through WAIT/EMIT.
    load_vec(1'b1, 1, int'(IN));
    post_load();
    drain(-1, 1'b1, -1, t);

    // Next frame element 0 must be the first byte offered back in LOAD.
    load_vec(1'b0, 1, int'(IN));
    post_load();
    drain(-1, 1'b0, -1, t);

    // Reset mid-load, then mid-EMIT, then a clean frame.
    load_vec(1'b0, 0, 60);
    do_reset();
    load_vec(1'b0, 0, int'(IN));
    post_load();
    drain(-1, 1'b0, 5, t);
    chk("emit_busy", 64'(busy), 64'(1));
    chk("emit_idx5", 64'(out_idx), 64'(5));
    do_reset();
    start = edge_cnt;
    load_vec(1'b0, 0, int'(IN));
    post_load();
    drain(-1, 1'b0, -1, t);
    chk("frame_after_rst", 64'(edge_cnt - start), 64'(158));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fc_seq_ctrl.md
FC_SEQ_CTRL -- requirements
Module: fc_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, input element width in bits.
REQ-002 Parameter: IN, 128, input vector length.
REQ-003 Parameter: N_OUT, 10, number of output neurons sequenced.
REQ-004 Parameter: Z_W, 23, neuron result width (post-ReLU, unsigned).
REQ-005 Parameter: SETTLE, 2, cycles allowed for combinational neuron path to settle (legal range 1..15).
REQ-006 Port: clk  in  1  single clock; all state on rising edge.
REQ-007 Port: rst  in  1  asynchronous, active-high reset.
REQ-008 Port: in_valid  in  1  input element valid.
REQ-009 Port: in_ready  out  1  block accepts input element.
REQ-010 Port: in_data  in  WIDTH  input element, arrives in index order 0..IN-1.
REQ-011 Port: x_vec  out  WIDTH*IN  buffered vector to neuron datapaths; element i at bits [i*WIDTH +: WIDTH].
REQ-012 Port: nsel  out  clog2(N_OUT)  neuron index driving the external result mux.
REQ-013 Port: z_in  in  Z_W  muxed neuron result selected by nsel.
REQ-014 Port: out_valid  out  1  result valid.
REQ-015 Port: out_ready  in  1  downstream accepts result.
REQ-016 Port: out_data  out  Z_W  registered neuron result.
REQ-017 Port: out_idx  out  clog2(N_OUT)  neuron index of out_data.
REQ-018 Port: out_last  out  1  high with out_valid when out_idx == N_OUT-1.
REQ-019 Port: busy  out  1  high in any state other than LOAD.

Function
REQ-020 FSM states: LOAD, WAIT, EMIT; encoding free.
REQ-021 LOAD: in_ready=1; on in_valid&&in_ready, buffer[wr_ptr]<=in_data, wr_ptr++.
REQ-022 Accept of element IN-1 shall clear wr_ptr, set nsel=0, load settle counter with SETTLE-1, go to WAIT next cycle.
REQ-023 in_ready shall be 0 in WAIT and EMIT; in_valid there shall be ignored, buffer unchanged.
REQ-024 x_vec shall be driven directly from buffer registers and shall not change outside LOAD.
REQ-025 WAIT: counter decrements each cycle; at zero, out_data<=z_in, out_idx<=nsel, go to EMIT (z_in sampled exactly SETTLE cycles after nsel change).
REQ-026 EMIT: out_valid=1; out_data/out_idx/out_last held stable until out_valid&&out_ready.
REQ-027 EMIT handshake with nsel<N_OUT-1: nsel++, counter reloaded SETTLE-1, go to WAIT.
REQ-028 EMIT handshake with nsel==N_OUT-1: nsel<=0, go to LOAD; in_ready high the following cycle.
REQ-029 out_ready while out_valid=0 shall have no effect.
REQ-030 Minimum frame time: IN + N_OUT*(SETTLE+1) cycles with continuous in_valid and out_ready.
REQ-031 Each result is unsigned Z_W bits, passed unmodified; no saturation or truncation.
REQ-032 nsel shall only change on LOAD->WAIT or EMIT handshake, never within WAIT.

Reset
REQ-033 rst asserted: immediately state=LOAD, wr_ptr=0, nsel=0, counter=0, all buffer elements 0, out_data=0, out_idx=0, out_valid=0, out_last=0, busy=0.
REQ-034 in_ready shall read 1 in the first cycle after rst deasserts.
REQ-035 rst mid-frame (any state) shall discard partial input and pending results; no out_valid until a full new vector is loaded.

Verification
REQ-036 IN=128, N_OUT=10, SETTLE=2; stream 0..127 back-to-back, model z_in=nsel*100+5, out_ready=1 -> ten results 5,105,...,905, idx 0..9, out_last only on 905, frame 158 cycles.
REQ-037 Backpressure: out_ready low 7 cycles during idx 3 -> out_data=305 held stable all 7 cycles, idx 4 appears 3 cycles after accept.
REQ-038 Bubbled input (in_valid toggling 50%) -> buffer element i equals i'th accepted byte; x_vec frozen (checked each cycle) through WAIT/EMIT.
REQ-039 in_valid held high during EMIT with data 0xFF -> in_ready=0, buffer unchanged, next frame element 0 is first byte after return to LOAD.
REQ-040 rst pulsed at element 60 and again in EMIT idx 5 -> outputs zero, busy=0, next frame loads from element 0, results 5..905 correct.
REQ-041 SETTLE=1, z_in changing only when nsel changes -> captured value always matches current nsel, frame 148 cycles.
